// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multicycle control unit: opcodes, functs,
// ALU operation codes, FSM states and the registered control bundle.
package mips_pkg;

   localparam int unsigned OP_W  = 6;
   localparam int unsigned FN_W  = 6;
   localparam int unsigned ALU_W = 4;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_PRINT = 6'b111111;

   localparam logic [FN_W-1:0] FN_ADD  = 6'b100000;
   localparam logic [FN_W-1:0] FN_SUB  = 6'b100010;
   localparam logic [FN_W-1:0] FN_AND  = 6'b100100;
   localparam logic [FN_W-1:0] FN_OR   = 6'b100101;
   localparam logic [FN_W-1:0] FN_NOR  = 6'b100111;
   localparam logic [FN_W-1:0] FN_SLT  = 6'b101010;
   localparam logic [FN_W-1:0] FN_SLL  = 6'b000000;
   localparam logic [FN_W-1:0] FN_SRL  = 6'b000010;
   localparam logic [FN_W-1:0] FN_MULT = 6'b011000;
   localparam logic [FN_W-1:0] FN_DIV  = 6'b011010;

   // ALU operation codes; 0000 is the idle code that arms the next re-evaluation
   localparam logic [ALU_W-1:0] ALU_NONE = 4'b0000;
   localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
   localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0110;
   localparam logic [ALU_W-1:0] ALU_AND  = 4'b1011;
   localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
   localparam logic [ALU_W-1:0] ALU_NOR  = 4'b1001;
   localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0111;
   localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0101;
   localparam logic [ALU_W-1:0] ALU_SRL  = 4'b1000;
   localparam logic [ALU_W-1:0] ALU_MULT = 4'b1111;
   localparam logic [ALU_W-1:0] ALU_DIV  = 4'b0011;
   localparam logic [ALU_W-1:0] ALU_BEQ  = 4'b1100;
   localparam logic [ALU_W-1:0] ALU_BNE  = 4'b0100;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_BRANCH, S_PRINT
   } state_t;

   typedef enum logic [2:0] {
      C_RTYPE, C_ADDI, C_LW, C_SW, C_BRANCH, C_JUMP, C_PRINT, C_ILLEGAL
   } instr_class_t;

   typedef struct packed {
      logic [ALU_W-1:0] alu_ctrl;
      logic             print;
      logic             shamt;
      logic             ir_write;
      logic             pc_inc;
      logic             pc_branch;
      logic             pc_jump;
      logic             reg_write;
      logic             reg_dst;
      logic             alu_src;
      logic             mem_to_reg;
      logic             mem_read;
      logic             mem_write;
      logic             illegal;
   } ctrl_t;

endpackage

// File: rtl/mips_control_unit_alu_control_decoder.sv
// Combinational opcode/funct decode into ALU code, datapath mux selects and
// an instruction class used by the sequencing FSM.
module alu_control_decoder
   import mips_pkg::*;
(
   input  logic [OP_W-1:0]  opcode,
   input  logic [FN_W-1:0]  funct,
   output logic [ALU_W-1:0] alu_ctrl_c,
   output logic             alu_src_c,
   output logic             reg_dst_c,
   output logic             illegal_c,
   output instr_class_t     iclass_c
);

   always_comb begin
      alu_ctrl_c = ALU_NONE;
      alu_src_c  = 1'b0;
      reg_dst_c  = 1'b0;
      iclass_c   = C_ILLEGAL;
      case (opcode)
         OP_RTYPE: begin
            iclass_c  = C_RTYPE;
            reg_dst_c = 1'b1;
            case (funct)
               FN_ADD:  alu_ctrl_c = ALU_ADD;
               FN_SUB:  alu_ctrl_c = ALU_SUB;
               FN_AND:  alu_ctrl_c = ALU_AND;
               FN_OR:   alu_ctrl_c = ALU_OR;
               FN_NOR:  alu_ctrl_c = ALU_NOR;
               FN_SLT:  alu_ctrl_c = ALU_SLT;
               FN_SLL:  alu_ctrl_c = ALU_SLL;
               FN_SRL:  alu_ctrl_c = ALU_SRL;
               FN_MULT: alu_ctrl_c = ALU_MULT;
               FN_DIV:  alu_ctrl_c = ALU_DIV;
               default: begin
                  iclass_c  = C_ILLEGAL;
                  reg_dst_c = 1'b0;
               end
            endcase
         end
         OP_ADDI: begin
            iclass_c   = C_ADDI;
            alu_ctrl_c = ALU_ADD;
            alu_src_c  = 1'b1;
         end
         OP_LW: begin
            iclass_c   = C_LW;
            alu_ctrl_c = ALU_ADD;
            alu_src_c  = 1'b1;
         end
         OP_SW: begin
            iclass_c   = C_SW;
            alu_ctrl_c = ALU_ADD;
            alu_src_c  = 1'b1;
         end
         OP_BEQ: begin
            iclass_c   = C_BRANCH;
            alu_ctrl_c = ALU_BEQ;
         end
         OP_BNE: begin
            iclass_c   = C_BRANCH;
            alu_ctrl_c = ALU_BNE;
         end
         OP_J:     iclass_c = C_JUMP;
         OP_PRINT: iclass_c = C_PRINT;
         default:  iclass_c = C_ILLEGAL;
      endcase
      illegal_c = (iclass_c == C_ILLEGAL);
   end

endmodule

// File: rtl/mips_control_unit.sv
// Multicycle MIPS control FSM. Outputs are registered alongside the state and
// describe the state being entered, so every strobe is glitch-free and resets async.
module mips_control_unit
   import mips_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic [31:0]      instruction,
   input  logic [31:0]      ALU_result,
   input  logic             mem_ready,
   output logic [ALU_W-1:0] ALUCtrl,
   output logic             print,
   output logic             shamt,
   output logic             ir_write,
   output logic             pc_inc,
   output logic             pc_branch,
   output logic             pc_jump,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             alu_src,
   output logic             mem_to_reg,
   output logic             mem_read,
   output logic             mem_write,
   output logic             illegal
);

   state_t           state, state_nxt;
   ctrl_t            ctrl_q, ctrl_nxt;
   logic             running;
   logic [ALU_W-1:0] dec_alu_ctrl;
   logic             dec_alu_src, dec_reg_dst, dec_illegal;
   instr_class_t     iclass;
   logic             unused_instr_bits;

   assign unused_instr_bits = ^{instruction[25:7]};

   alu_control_decoder u_dec (
      .opcode     (instruction[31:26]),
      .funct      (instruction[5:0]),
      .alu_ctrl_c (dec_alu_ctrl),
      .alu_src_c  (dec_alu_src),
      .reg_dst_c  (dec_reg_dst),
      .illegal_c  (dec_illegal),
      .iclass_c   (iclass)
   );

   // running holds off the first FETCH until the first edge after reset release
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_FETCH;
         ctrl_q  <= '0;
         running <= 1'b0;
      end else begin
         state   <= state_nxt;
         ctrl_q  <= ctrl_nxt;
         running <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      ctrl_nxt  = '0;
      if (!running) begin
         state_nxt = S_FETCH;
      end else begin
         case (state)
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
               case (iclass)
                  C_JUMP, C_ILLEGAL: state_nxt = S_FETCH;
                  C_PRINT:           state_nxt = S_PRINT;
                  default:           state_nxt = S_EXECUTE;
               endcase
            end
            S_EXECUTE: begin
               case (iclass)
                  C_LW, C_SW:      state_nxt = S_MEM;
                  C_BRANCH:        state_nxt = S_BRANCH;
                  C_RTYPE, C_ADDI: state_nxt = S_WRITEBACK;
                  default:         state_nxt = S_FETCH;
               endcase
            end
            S_MEM: begin
               if (mem_ready) state_nxt = (iclass == C_LW) ? S_WRITEBACK : S_FETCH;
            end
            default: state_nxt = S_FETCH;
         endcase
      end

      // ALUCtrl stays zero outside EXECUTE so back-to-back identical ops re-trigger
      case (state_nxt)
         S_FETCH: begin
            ctrl_nxt.ir_write = 1'b1;
            ctrl_nxt.pc_inc   = 1'b1;
         end
         S_DECODE: begin
            ctrl_nxt.pc_jump = (iclass == C_JUMP);
            ctrl_nxt.illegal = dec_illegal;
         end
         S_EXECUTE: begin
            ctrl_nxt.alu_ctrl = dec_alu_ctrl;
            ctrl_nxt.alu_src  = dec_alu_src;
            ctrl_nxt.shamt    = instruction[6];
         end
         S_MEM: begin
            ctrl_nxt.mem_read  = (iclass == C_LW);
            ctrl_nxt.mem_write = (iclass == C_SW);
         end
         S_WRITEBACK: begin
            ctrl_nxt.reg_write  = 1'b1;
            ctrl_nxt.reg_dst    = dec_reg_dst;
            ctrl_nxt.mem_to_reg = (iclass == C_LW);
         end
         S_BRANCH: ctrl_nxt.pc_branch = (ALU_result != 32'd0);
         S_PRINT:  ctrl_nxt.print     = 1'b1;
         default:  ctrl_nxt           = '0;
      endcase
   end

   assign ALUCtrl    = ctrl_q.alu_ctrl;
   assign print      = ctrl_q.print;
   assign shamt      = ctrl_q.shamt;
   assign ir_write   = ctrl_q.ir_write;
   assign pc_inc     = ctrl_q.pc_inc;
   assign pc_branch  = ctrl_q.pc_branch;
   assign pc_jump    = ctrl_q.pc_jump;
   assign reg_write  = ctrl_q.reg_write;
   assign reg_dst    = ctrl_q.reg_dst;
   assign alu_src    = ctrl_q.alu_src;
   assign mem_to_reg = ctrl_q.mem_to_reg;
   assign mem_read   = ctrl_q.mem_read;
   assign mem_write  = ctrl_q.mem_write;
   assign illegal    = ctrl_q.illegal;

endmodule
